mem_copy_engine: RTL and testbench
==================================

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter AW, default 8: Memory address width.
REQ-002 Parameter DW, default 16: Memory data width.
REQ-003 Ports are clk and reset_L; one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 reset_L  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request a copy; sampled only in IDLE.
REQ-007 src  input  AW  first source word address.
REQ-008 dst  input  AW  first destination word address.
REQ-009 len  input  AW  number of words to copy (0..2^AW-1).
REQ-010 busy  output  1  high while a copy is in progress.
REQ-011 done  output  1  one-cycle pulse when a copy completes.
REQ-012 Address  output  AW  Memory address bus.
REQ-013 re  output  1  Memory read enable.
REQ-014 we  output  1  Memory write enable.
REQ-015 Data  inout (tri)  DW  shared Memory data bus.

Function
REQ-016 The block SHALL act as bus master for the Memory, which drives Data combinationally while re=1 and writes Data at the posedge where we=1.
REQ-017 The FSM SHALL have states IDLE, READ, WRITE, FIN.
REQ-018 IDLE: when start=1 at a posedge, the block SHALL latch src, dst and len, clear index i to 0, and go to READ (len!=0) or FIN (len=0).
REQ-019 READ (1 cycle): Address=src_l+i, re=1, we=0; the block SHALL capture Data into a DW-bit hold register at the closing posedge and go to WRITE.
REQ-020 WRITE (1 cycle): Address=dst_l+i, we=1, re=0, Data=hold; at the closing posedge i increments; next state is READ if i+1<len_l, else FIN.
REQ-021 FIN (1 cycle): done=1; the next state SHALL be IDLE.
REQ-022 Throughput SHALL be 2 cycles per word; a copy of N>0 words SHALL take 2N+1 cycles from the start edge to the done cycle, inclusive.
REQ-023 busy SHALL be 1 in READ, WRITE and FIN, and 0 in IDLE.
REQ-024 Address arithmetic SHALL be modulo 2^AW; src_l+i and dst_l+i wrap from 2^AW-1 to 0.
REQ-025 The copy SHALL proceed in ascending address order; if regions overlap with dst>src, already-written words are re-read (defined behaviour, no error).
REQ-026 The block SHALL drive Data only in WRITE and SHALL present high-Z at all other times, including during reset.
REQ-027 re and we SHALL never both be 1; in IDLE and FIN both SHALL be 0 and Address SHALL be 0.
REQ-028 start asserted while busy=1 SHALL be ignored; src, dst and len changes while busy SHALL have no effect.
REQ-029 start held high in FIN SHALL begin a new copy only at the IDLE posedge that follows.

Reset
REQ-030 On reset_L=0 the block SHALL immediately enter IDLE with i=0 and hold=0, and drive busy=0, done=0, re=0, we=0, Address=0 and Data=Z.
REQ-031 A reset mid-copy SHALL abort the copy without completing the current write and without a done pulse.

Structure
REQ-032 A shared package (mem_copy_pkg) SHALL hold the state enum and the AW/DW default constants.
REQ-033 One sub-module, mem_copy_datapath, SHALL hold the index counter, the two address adders, the latched src/dst/len and the hold register; the FSM stays in the top.

Verification
REQ-034 Preload M[16..19]=A,B,C,D; src=16, dst=64, len=4, start pulse -> M[64..67]=A,B,C,D; done exactly at cycle 9 after start; busy high for cycles 1..9.
REQ-035 len=0 with start -> done on the next cycle; re and we never asserted; memory unchanged.
REQ-036 src=254, dst=1, len=3; M[254]=7, M[255]=8, M[0]=9 -> M[1..3]=7,8,9 via address wrap.
REQ-037 start pulsed again in cycle 3 of a len=4 copy with new src/dst -> ignored; only the first copy occurs; a single done pulse.
REQ-038 reset_L low during the second WRITE of a len=4 copy -> outputs at reset values immediately; Data=Z; only one word written; no done pulse.
REQ-039 Bench monitor on every cycle: never re&we; Data is Z whenever we=0.

Source files
------------

// File: rtl/mem_copy_pkg.sv
//------------------------------------------------------------------------------
// Module   : mem_copy_pkg
// Brief    : Shared FSM state encoding and default widths for the copy engine.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_copy_pkg;

    localparam int AW_DEFAULT = 8;
    localparam int DW_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/mem_copy_datapath.sv
//------------------------------------------------------------------------------
// Module   : mem_copy_datapath
// Brief    : Index counter, latched copy descriptor, hold register and the
//            source/destination address adders for the copy engine.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_copy_datapath
    import mem_copy_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          load,
    input  logic          inc,
    input  logic          capture,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] len,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] hold,
    output logic [AW-1:0] rd_addr_next,
    output logic [AW-1:0] wr_addr_next,
    output logic          last
);

    logic [AW-1:0] i_q, i_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] len_q, len_d;
    logic [DW-1:0] hold_q, hold_d;
    logic [AW:0]   w_i_plus1;

    always_comb begin
        src_d  = load ? src : src_q;
        dst_d  = load ? dst : dst_q;
        len_d  = load ? len : len_q;
        hold_d = capture ? data_in : hold_q;
        i_d    = i_q;
        if (load) begin
            i_d = '0;
        end else if (inc) begin
            i_d = i_q + {{(AW-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            i_q    <= '0;
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            hold_q <= '0;
        end else begin
            i_q    <= i_d;
            src_q  <= src_d;
            dst_q  <= dst_d;
            len_q  <= len_d;
            hold_q <= hold_d;
        end
    end

    // Addresses are formed from next-cycle values so the top can register them;
    // truncation to AW bits gives the modulo-2^AW wrap.
    assign rd_addr_next = src_d + i_d;
    assign wr_addr_next = dst_d + i_d;

    // One extra bit keeps i+1 exact when i sits at the top of the range.
    assign w_i_plus1 = {1'b0, i_q} + {{AW{1'b0}}, 1'b1};
    assign last      = (w_i_plus1 >= {1'b0, len_q});
    assign hold      = hold_q;

endmodule

`default_nettype wire

// File: rtl/mem_copy_engine.sv
//------------------------------------------------------------------------------
// Module   : mem_copy_engine
// Brief    : Bus-master block copy engine, one word per READ/WRITE pair.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          start,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] Address,
    output logic          re,
    output logic          we,
    inout  tri   [DW-1:0] Data
);

    state_e        state_q, state_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          re_q, re_d;
    logic          we_q, we_d;
    logic          drive_q, drive_d;
    logic [AW-1:0] addr_q, addr_d;

    logic          w_load;
    logic          w_inc;
    logic          w_capture;
    logic          w_last;
    logic [DW-1:0] w_hold;
    logic [AW-1:0] w_rd_addr_next;
    logic [AW-1:0] w_wr_addr_next;

    mem_copy_datapath #(
        .AW (AW),
        .DW (DW)
    ) u_datapath (
        .clk          (clk),
        .reset_L      (reset_L),
        .load         (w_load),
        .inc          (w_inc),
        .capture      (w_capture),
        .src          (src),
        .dst          (dst),
        .len          (len),
        .data_in      (Data),
        .hold         (w_hold),
        .rd_addr_next (w_rd_addr_next),
        .wr_addr_next (w_wr_addr_next),
        .last         (w_last)
    );

    always_comb begin
        state_d   = state_q;
        w_load    = 1'b0;
        w_inc     = 1'b0;
        w_capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    w_load  = 1'b1;
                    state_d = (len != '0) ? READ : FIN;
                end
            end
            READ: begin
                w_capture = 1'b1;
                state_d   = WRITE;
            end
            WRITE: begin
                w_inc   = 1'b1;
                state_d = w_last ? FIN : READ;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they come straight off flops.
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == FIN);
        re_d    = (state_d == READ);
        we_d    = (state_d == WRITE);
        drive_d = (state_d == WRITE);
        addr_d  = '0;
        if (state_d == READ) begin
            addr_d = w_rd_addr_next;
        end else if (state_d == WRITE) begin
            addr_d = w_wr_addr_next;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            drive_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            re_q    <= re_d;
            we_q    <= we_d;
            drive_q <= drive_d;
            addr_q  <= addr_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign re      = re_q;
    assign we      = we_q;
    assign Address = addr_q;
    assign Data    = drive_q ? w_hold : {DW{1'bz}};

endmodule

`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_copy_engine
// Brief    : Directed bench with a write scoreboard and a per-cycle bus monitor.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_copy_engine;

    localparam int AW = 8;
    localparam int DW = 16;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk     = 1'b0;
    logic          reset_L = 1'b0;
    logic          start   = 1'b0;
    logic [AW-1:0] src     = '0;
    logic [AW-1:0] dst     = '0;
    logic [AW-1:0] len     = '0;
    wire           busy;
    wire           done;
    wire           re;
    wire           we;
    wire  [AW-1:0] addr;
    // Pulled-up bus: an undriven bus reads all ones.
    tri1  [DW-1:0] data_bus;

    logic [DW-1:0] mem [0:255];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_a  = '0;
    logic [DW-1:0] pl_d  = '0;

    wr_t  exp_q[$];
    wr_t  mon_e;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    int   d0;

    always #5 clk = ~clk;

    mem_copy_engine #(
        .AW (AW),
        .DW (DW)
    ) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .start   (start),
        .src     (src),
        .dst     (dst),
        .len     (len),
        .busy    (busy),
        .done    (done),
        .Address (addr),
        .re      (re),
        .we      (we),
        .Data    (data_bus)
    );

    assign data_bus = re ? mem[addr] : {DW{1'bz}};

    always @(posedge clk) begin
        if (we) begin
            mem[addr] <= data_bus;
        end else if (pl_en) begin
            mem[pl_a] <= pl_d;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("no_re_and_we", {31'd0, re & we}, 32'd0);
        if (!we && !re) chk("bus_released", {16'd0, data_bus}, 32'h0000_FFFF);
        if (we) begin
            chk("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", {24'd0, addr}, {24'd0, mon_e.a});
                chk("wr_data", {16'd0, data_bus}, {16'd0, mon_e.d});
            end
        end
        if (done) done_cnt++;
    end

    task automatic pl(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        pl_en = 1'b1;
        pl_a  = a;
        pl_d  = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic go(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW-1:0] l);
        @(negedge clk);
        start = 1'b1;
        src   = s;
        dst   = d;
        len   = l;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_re",   {31'd0, re},   32'd0);
        chk("rst_we",   {31'd0, we},   32'd0);
        chk("rst_addr", {24'd0, addr}, 32'd0);
        chk("rst_bus",  {16'd0, data_bus}, 32'h0000_FFFF);
        reset_L = 1'b1;

        pl(8'd16, 16'hAAAA); pl(8'd17, 16'hBBBB); pl(8'd18, 16'hCCCC); pl(8'd19, 16'hDDDD);
        pl(8'd6, 16'h1234);
        pl(8'd254, 16'd7); pl(8'd255, 16'd8); pl(8'd0, 16'd9);
        for (int k = 0; k < 4; k++) pl(8'(32 + k), 16'h3200 + 16'(k));
        pl(8'd100, 16'h0BAD);
        pl(8'd48, 16'h4800); pl(8'd49, 16'h4801); pl(8'd113, 16'h5EED);

        // Four-word copy with exact cycle timing
        d0 = done_cnt;
        exp_q.push_back('{a: 8'd64, d: 16'hAAAA});
        exp_q.push_back('{a: 8'd65, d: 16'hBBBB});
        exp_q.push_back('{a: 8'd66, d: 16'hCCCC});
        exp_q.push_back('{a: 8'd67, d: 16'hDDDD});
        go(8'd16, 8'd64, 8'd4);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            chk($sformatf("c1_busy_cyc%0d", c), {31'd0, busy}, {31'd0, c <= 9});
            chk($sformatf("c1_done_cyc%0d", c), {31'd0, done}, {31'd0, c == 9});
            if (c == 1) begin
                chk("c1_first_re",   {31'd0, re},   32'd1);
                chk("c1_first_addr", {24'd0, addr}, 32'd16);
            end
        end
        chk("c1_m64", {16'd0, mem[64]}, 32'h0000_AAAA);
        chk("c1_m65", {16'd0, mem[65]}, 32'h0000_BBBB);
        chk("c1_m66", {16'd0, mem[66]}, 32'h0000_CCCC);
        chk("c1_m67", {16'd0, mem[67]}, 32'h0000_DDDD);
        chk("c1_queue_empty", exp_q.size(), 32'd0);
        #1 chk("c1_done_pulses", done_cnt - d0, 32'd1);

        // Zero-length copy
        d0 = done_cnt;
        go(8'd5, 8'd6, 8'd0);
        @(negedge clk);
        chk("z_done1", {31'd0, done}, 32'd1);
        chk("z_busy1", {31'd0, busy}, 32'd1);
        chk("z_re",    {31'd0, re},   32'd0);
        chk("z_we",    {31'd0, we},   32'd0);
        @(negedge clk);
        chk("z_done2", {31'd0, done}, 32'd0);
        chk("z_busy2", {31'd0, busy}, 32'd0);
        chk("z_m6",    {16'd0, mem[6]}, 32'h0000_1234);
        #1 chk("z_done_pulses", done_cnt - d0, 32'd1);

        // Address wrap on the source side
        exp_q.push_back('{a: 8'd1, d: 16'd7});
        exp_q.push_back('{a: 8'd2, d: 16'd8});
        exp_q.push_back('{a: 8'd3, d: 16'd9});
        go(8'd254, 8'd1, 8'd3);
        repeat (8) @(negedge clk);
        chk("w_m1", {16'd0, mem[1]}, 32'd7);
        chk("w_m2", {16'd0, mem[2]}, 32'd8);
        chk("w_m3", {16'd0, mem[3]}, 32'd9);
        chk("w_queue_empty", exp_q.size(), 32'd0);

        // Start while busy is ignored
        d0 = done_cnt;
        for (int k = 0; k < 4; k++) exp_q.push_back('{a: 8'(96 + k), d: 16'h3200 + 16'(k)});
        go(8'd32, 8'd96, 8'd4);
        repeat (2) @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        src   = 8'd40;
        dst   = 8'd100;
        len   = 8'd2;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        #1 chk("ign_done_pulses", done_cnt - d0, 32'd1);
        chk("ign_m100",    {16'd0, mem[100]}, 32'h0000_0BAD);
        chk("ign_m99",     {16'd0, mem[99]},  32'h0000_3203);
        chk("ign_queue_empty", exp_q.size(), 32'd0);

        // Reset during the second WRITE
        d0 = done_cnt;
        exp_q.push_back('{a: 8'd112, d: 16'h4800});
        go(8'd48, 8'd112, 8'd4);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        chk("r_in_write", {31'd0, we}, 32'd1);
        reset_L = 1'b0;
        #1;
        chk("r_busy", {31'd0, busy}, 32'd0);
        chk("r_done", {31'd0, done}, 32'd0);
        chk("r_re",   {31'd0, re},   32'd0);
        chk("r_we",   {31'd0, we},   32'd0);
        chk("r_addr", {24'd0, addr}, 32'd0);
        chk("r_bus",  {16'd0, data_bus}, 32'h0000_FFFF);
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        repeat (4) @(negedge clk);
        chk("r_m112", {16'd0, mem[112]}, 32'h0000_4800);
        chk("r_m113", {16'd0, mem[113]}, 32'h0000_5EED);
        chk("r_busy_after", {31'd0, busy}, 32'd0);
        chk("r_queue_empty", exp_q.size(), 32'd0);
        #1 chk("r_done_pulses", done_cnt - d0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
